// File: rtl/tcu_reset_pkg.sv
`default_nettype none
// ============================================================================
// Module : tcu_reset_pkg
// Brief  : Shared types and constants for the TCU control reset handshake.
// Rev    : 1.0 - initial release
// ============================================================================
package tcu_reset_pkg;

    // Receiver wraps a 4-bit counter, so the initiator must wait this long.
    localparam int unsigned TCU_STRETCH_CYCLES = 16;

    typedef logic [1:0] status_t;

    localparam status_t ST_OK       = 2'b00;
    localparam status_t ST_DRAIN_TO = 2'b01;
    localparam status_t ST_ACK_TO   = 2'b10;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        DRAIN        = 3'd1,
        PULSE        = 3'd2,
        WAIT_ASSERT  = 3'd3,
        WAIT_RELEASE = 3'd4,
        RESP         = 3'd5
    } tcu_rst_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tcu_reset_initiator_if.sv
`default_nettype none
// ============================================================================
// Module : tcu_reset_initiator_if
// Brief  : Command / response handshake between a requester and the initiator.
// Rev    : 1.0 - initial release
// ============================================================================
interface tcu_reset_initiator_if;
    import tcu_reset_pkg::*;

    logic    cmd_valid_i;
    logic    cmd_force_i;
    logic    cmd_ready_o;
    logic    resp_valid_o;
    status_t resp_status_o;
    logic    resp_ready_i;

    modport master (
        output cmd_valid_i,
        output cmd_force_i,
        output resp_ready_i,
        input  cmd_ready_o,
        input  resp_valid_o,
        input  resp_status_o
    );

    modport slave (
        input  cmd_valid_i,
        input  cmd_force_i,
        input  resp_ready_i,
        output cmd_ready_o,
        output resp_valid_o,
        output resp_status_o
    );

endinterface
`default_nettype wire

// File: rtl/tcu_reset_initiator.sv
`default_nettype none
// ============================================================================
// Module : tcu_reset_initiator
// Brief  : Drains the TCU, emits a one-cycle reset pulse, tracks the receiver's
//          synchronised reset feedback and returns a completion status.
// Rev    : 1.0 - initial release
// ============================================================================
module tcu_reset_initiator
    import tcu_reset_pkg::*;
#(
    parameter int unsigned DRAIN_TIMEOUT  = 1024,
    parameter int unsigned STRETCH_CYCLES = TCU_STRETCH_CYCLES,
    parameter int unsigned ACK_TIMEOUT    = 64
) (
    input  wire                  clk_i,
    input  wire                  reset_n_i,
    tcu_reset_initiator_if.slave cmd_if,
    output logic                 drain_req_o,
    input  wire                  tcu_idle_i,
    output logic                 tcu_reset_o,
    input  wire                  reset_sync_n_i,
    output logic                 busy_o
);

    localparam int unsigned c_CNT_W = $clog2(max_u(DRAIN_TIMEOUT, ACK_TIMEOUT) + 1);

    localparam logic [c_CNT_W-1:0] c_DRAIN_LAST = c_CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_ACK_LAST   = c_CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_STRETCH    = c_CNT_W'(STRETCH_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT    = {c_CNT_W{1'b1}};

    tcu_rst_state_e       r_state;
    tcu_rst_state_e       w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    status_t              r_status;
    status_t              w_status_nxt;
    logic                 w_cnt_clr;

    logic                 r_cmd_ready;
    logic                 r_drain_req;
    logic                 r_tcu_reset;
    logic                 r_resp_valid;
    status_t              r_resp_status;
    logic                 r_busy;

    always_comb begin
        w_state_nxt  = r_state;
        w_status_nxt = r_status;
        case (r_state)
            IDLE: begin
                // r_cmd_ready is low for the first cycle out of reset
                if (cmd_if.cmd_valid_i && r_cmd_ready) begin
                    w_status_nxt = ST_OK;
                    w_state_nxt  = cmd_if.cmd_force_i ? PULSE : DRAIN;
                end
            end
            DRAIN: begin
                if (tcu_idle_i) begin
                    w_state_nxt  = PULSE;
                    w_status_nxt = ST_OK;
                end else if (r_cnt == c_DRAIN_LAST) begin
                    w_state_nxt  = PULSE;
                    w_status_nxt = ST_DRAIN_TO;
                end
            end
            PULSE: begin
                w_state_nxt = WAIT_ASSERT;
            end
            WAIT_ASSERT: begin
                if (r_cnt == c_ACK_LAST) begin
                    w_state_nxt  = RESP;
                    w_status_nxt = ST_ACK_TO;
                end else if (!reset_sync_n_i) begin
                    w_state_nxt = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                // Early release is ignored until the receiver's stretch has elapsed
                if (reset_sync_n_i && (r_cnt >= c_STRETCH)) begin
                    w_state_nxt = RESP;
                end else if (r_cnt == c_ACK_LAST) begin
                    w_state_nxt  = RESP;
                    w_status_nxt = ST_ACK_TO;
                end
            end
            RESP: begin
                if (cmd_if.resp_ready_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // The wait states keep counting from the pulse so the count is time-since-pulse.
    assign w_cnt_clr = (w_state_nxt != r_state) &&
                       (w_state_nxt != WAIT_ASSERT) && (w_state_nxt != WAIT_RELEASE);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_status      <= ST_OK;
            r_cmd_ready   <= 1'b0;
            r_drain_req   <= 1'b0;
            r_tcu_reset   <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_resp_status <= ST_OK;
            r_busy        <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_status <= w_status_nxt;
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (r_cnt != c_CNT_SAT) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
            r_cmd_ready   <= (w_state_nxt == IDLE);
            r_drain_req   <= (w_state_nxt == DRAIN) || (w_state_nxt == PULSE) ||
                             (w_state_nxt == WAIT_ASSERT) || (w_state_nxt == WAIT_RELEASE);
            r_tcu_reset   <= (w_state_nxt == PULSE);
            r_resp_valid  <= (w_state_nxt == RESP);
            r_resp_status <= (w_state_nxt == RESP) ? w_status_nxt : ST_OK;
            r_busy        <= (w_state_nxt != IDLE);
        end
    end

    assign cmd_if.cmd_ready_o   = r_cmd_ready;
    assign cmd_if.resp_valid_o  = r_resp_valid;
    assign cmd_if.resp_status_o = r_resp_status;
    assign drain_req_o          = r_drain_req;
    assign tcu_reset_o          = r_tcu_reset;
    assign busy_o               = r_busy;

endmodule
`default_nettype wire

// File: doc/tcu_reset_initiator.md
Name: tcu_reset_initiator

Overview:
- Initiator side of the TCU control reset handshake. It accepts a reset command, optionally drains outstanding TCU activity, and issues the single-cycle tcu_reset pulse that the TCU reset receiver stretches and synchronises.
- It then tracks the receiver's synchronised reset feedback through assertion and release, and returns a status response.
- It sits in the TCU control path, clocked with the TCU. It resets only from reset_n_i, never from the TCU reset it generates.

Parameters:
- DRAIN_TIMEOUT, 1024: max cycles to wait for tcu_idle_i in DRAIN before forcing the reset.
- STRETCH_CYCLES, 16: minimum cycles from pulse to accepted release. Matches the receiver's 4-bit wrap counter.
- ACK_TIMEOUT, 64: max cycles from pulse until feedback has gone low and back high.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset, asynchronous, active-low; clock clk_i
- cmd_valid_i  in  1  reset command request
- cmd_force_i  in  1  sampled with the command; 1 = skip DRAIN
- cmd_ready_o  out  1  command accepted when valid&ready
- drain_req_o  out  1  asks TCU units to stop accepting new work
- tcu_idle_i  in  1  TCU units have no outstanding transactions
- tcu_reset_o  out  1  single-cycle reset pulse to the receiver
- reset_sync_n_i  in  1  receiver's synchronised active-low reset (feedback)
- resp_valid_o  out  1  completion response valid
- resp_status_o  out  2  00 ok, 01 drain timeout (reset still done), 10 ack timeout, 11 reserved (never driven)
- resp_ready_i  in  1  response consumed when valid&ready
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counter 0; status 00.
- Counter:
  - Single counter, width $clog2(max(DRAIN_TIMEOUT, ACK_TIMEOUT)+1).
  - Cleared on every state entry.
  - Saturates and never wraps.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i: latch cmd_force_i, clear status.
  - Go to PULSE if force, else to DRAIN.
- DRAIN:
  - drain_req_o=1.
  - tcu_idle_i=1 -> PULSE, status 00.
  - Counter reaching DRAIN_TIMEOUT-1 without idle -> PULSE, status 01.
  - tcu_idle_i high on the same cycle as the timeout -> idle wins (status 00).
- PULSE:
  - Exactly one cycle: tcu_reset_o=1, drain_req_o=1.
  - Go to WAIT_ASSERT.
  - tcu_reset_o is high for exactly one cycle per accepted command, at all times.
- WAIT_ASSERT:
  - reset_sync_n_i=0 -> WAIT_RELEASE.
  - Counter continues from pulse, cleared only on PULSE entry; counts cycles since pulse.
- WAIT_RELEASE:
  - Requires reset_sync_n_i=1 AND counter >= STRETCH_CYCLES -> RESP.
  - An early release (counter < STRETCH) is ignored until the minimum has elapsed.
- Ack timeout: in WAIT_ASSERT or WAIT_RELEASE, counter reaching ACK_TIMEOUT-1 -> RESP with status 10. This overrides 01.
- RESP:
  - resp_valid_o=1, resp_status_o stable, drain_req_o=0.
  - Hold until resp_ready_i -> IDLE.
  - Next command accepted no earlier than the cycle after the handshake.
- cmd_ready_o=0 in every state except IDLE. A command arriving while busy is stalled, not dropped.
- Latency for force, ideal receiver: accept at cycle 0, pulse at cycle 1, resp_valid at cycle 1+STRETCH_CYCLES at the earliest.
- Reset mid-operation (reset_n_i low): immediate return to IDLE, all outputs 0, no pulse emitted. Any in-flight command is lost.
- drain_req_o is deasserted at RESP entry.

Decomposition:
- Shared package tcu_reset_pkg:
  - State enum: IDLE, DRAIN, PULSE, WAIT_ASSERT, WAIT_RELEASE, RESP.
  - Status constants: ST_OK, ST_DRAIN_TO, ST_ACK_TO.
  - Default STRETCH_CYCLES=16, shared with the receiver.
- No sub-module: a single FSM plus counter. The bench pairs it with the existing receiver to close the loop.

Test Plan:
- cmd_force=1, receiver connected -> one-cycle tcu_reset_o at cycle 1; resp_valid with status 00 at cycle >= 17.
- cmd_force=0, tcu_idle_i rises 10 cycles after accept -> drain_req_o high for 10 cycles, then pulse, then status 00.
- cmd_force=0, tcu_idle_i stuck 0, DRAIN_TIMEOUT=8 -> pulse after 8 DRAIN cycles; status 01.
- reset_sync_n_i tied 1, ACK_TIMEOUT=64 -> resp at pulse+64, status 10. Feedback released at pulse+5 -> resp not before pulse+16.
- resp_ready_i low for 20 cycles with a second cmd_valid held -> resp_status stable and cmd_ready_o=0 throughout; second command accepted the cycle after the handshake, producing a second pulse.
- reset_n_i asserted in WAIT_RELEASE -> all outputs 0 immediately; after release, IDLE with cmd_ready_o=1 and no spurious pulse.
